pin_conditioner: RTL
====================

PIN_CONDITIONER -- requirements
Module: pin_conditioner

Interface
REQ-001 SHALL have parameter IO_PINS, default 4, the number of I/O pins conditioned.
REQ-002 SHALL have parameter FILTER_BITS, default 3, the width of each per-pin stability counter and of filter_len.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port pin_dir, input, IO_PINS bits; per pin, 1 = input (conditioned), 0 = output (conditioner idle).
REQ-006 SHALL have port pad_in, input, IO_PINS bits, the raw asynchronous pad levels.
REQ-007 SHALL have port filter_len, input, FILTER_BITS bits, the quasi-static debounce length N.
REQ-008 SHALL have port pin_data_out, output, IO_PINS bits, the debounced level; it drives the io filter's pin_data_in.
REQ-009 SHALL have port rise, output, IO_PINS bits, a one-cycle pulse when the debounced level goes 0->1.
REQ-010 SHALL have port fall, output, IO_PINS bits, a one-cycle pulse when the debounced level goes 1->0.

Function (per pin, all pins independent)
REQ-011 SHALL pass pad_in through a two-flop synchronizer (sync1 -> sync2) regardless of pin_dir.
REQ-012 SHALL hold the registers stable (drives pin_data_out) and count (FILTER_BITS bits).
REQ-013 Input pin with sync2 == stable: SHALL load count <= 0; stable is unchanged.
REQ-014 Input pin with sync2 != stable and count >= filter_len: SHALL load stable <= sync2 and count <= 0, and pulse rise or fall per the new level.
REQ-015 Input pin with sync2 != stable and count < filter_len: SHALL load count <= count+1; count never wraps.
REQ-016 Latency: a clean pad_in level change SHALL reach pin_data_out N+3 rising edges after first sampling; N=0 gives 3 edges.
REQ-017 A pad glitch that leaves sync2 differing for at most N consecutive cycles SHALL be rejected, with no output change and no pulse.
REQ-018 rise and fall SHALL be registered, asserted in the same cycle stable first shows its new value, and deasserted the following cycle; rise & fall is never 1.
REQ-019 Lowering filter_len below a running count SHALL cause the transition to be accepted on the next differing cycle (>= compare).
REQ-020 Output pin (pin_dir=0): stable and count SHALL be forced to 0, pin_data_out=0, and no pulses are produced.
REQ-021 On pin_dir 0->1, filtering SHALL start from stable=0, count=0; a high pad gives rise N+1 edges later, since the synchronizer is already primed.
REQ-022 On pin_dir 1->0 while stable=1, pin_data_out SHALL drop to 0 on the next edge with no fall pulse.

Reset
REQ-023 rst_n low SHALL asynchronously clear sync1, sync2, stable, count, rise and fall to 0.
REQ-024 Reset mid-count SHALL discard the partial count; after release, a high pad needs the full N+3 latency again and produces a rise pulse.
REQ-025 Reset deassertion SHALL take effect on the first rising edge after rst_n goes high; no output pulses are produced during reset.

Structure
REQ-026 SHALL use no shared package; IO_PINS and FILTER_BITS are plain parameters, matching io_filter's IO_PINS.
REQ-027 SHALL instantiate one sub-module, pin_debounce_cell (one pin: synchronizer, counter, stable, edge pulses), IO_PINS times via generate.
REQ-028 SHALL contain no combinational path from pad_in to any output.

Verification
REQ-029 Reset held 40 time units, pin_dir=4'b1111, N=0, pad_in 4'b0000->4'b0001 -> pin_data_out=4'b0001 exactly 3 edges later; rise=4'b0001 for one cycle.
REQ-030 N=3, pad_in[1] high for 3 cycles then low -> pin_data_out[1] stays 0; no pulses. Same pin held high for 10 cycles -> pin_data_out[1]=1 at edge 6; one rise pulse.
REQ-031 pin_dir=4'b0101 with pad_in=4'b1111 -> pin_data_out=4'b0101 after latency; bits 1 and 3 stay 0 with no pulses.
REQ-032 N=7, count at 5, filter_len changed to 2 -> transition accepted on the next differing cycle; single pulse.
REQ-033 N=3, pin high and stable, pad_in low, rst_n pulsed low for one cycle mid-count -> all outputs 0 immediately; pin_data_out stays 0 with no fall pulse after release.
REQ-034 Bench SHALL check rise & fall == 0 and a pulse width of exactly one cycle on every cycle of every scenario.

Source files
------------

// File: rtl/pin_conditioner_if.sv
// Per-pin link between the conditioner top and one debounce cell.
interface pin_conditioner_if;
  logic dir;
  logic pad;
  logic data;
  logic rise;
  logic fall;

  modport master (output dir, output pad, input data, input rise, input fall);
  modport slave  (input dir, input pad, output data, output rise, output fall);
endinterface

// File: rtl/pin_debounce_cell.sv
// One pin: two-flop synchronizer, stability counter, debounced level and edge pulses.
module pin_debounce_cell #(
  parameter int unsigned FILTER_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FILTER_BITS-1:0] filter_len,
  pin_conditioner_if.slave       pin
);

  logic                   sync1_q, sync2_q;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [FILTER_BITS-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      count_q  <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= pin.pad;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      count_q  <= count_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // The >= compare lets a lowered filter_len release a count already past it.
  always_comb begin
    stable_d = stable_q;
    count_d  = count_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (!pin.dir) begin
      stable_d = 1'b0;
      count_d  = '0;
    end else if (sync2_q == stable_q) begin
      count_d = '0;
    end else if (count_q >= filter_len) begin
      stable_d = sync2_q;
      count_d  = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      count_d = count_q + FILTER_BITS'(1);
    end
  end

  assign pin.data = stable_q;
  assign pin.rise = rise_q;
  assign pin.fall = fall_q;

endmodule

// File: rtl/pin_conditioner.sv
// Debounces IO_PINS pad inputs independently; output-direction pins are held idle at 0.
module pin_conditioner #(
  parameter int unsigned IO_PINS     = 4,
  parameter int unsigned FILTER_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IO_PINS-1:0]     pin_dir,
  input  logic [IO_PINS-1:0]     pad_in,
  input  logic [FILTER_BITS-1:0] filter_len,
  output logic [IO_PINS-1:0]     pin_data_out,
  output logic [IO_PINS-1:0]     rise,
  output logic [IO_PINS-1:0]     fall
);

  for (genvar i = 0; i < IO_PINS; i++) begin : g_pin
    pin_conditioner_if u_pin_if ();

    assign u_pin_if.dir    = pin_dir[i];
    assign u_pin_if.pad    = pad_in[i];
    assign pin_data_out[i] = u_pin_if.data;
    assign rise[i]         = u_pin_if.rise;
    assign fall[i]         = u_pin_if.fall;

    pin_debounce_cell #(
      .FILTER_BITS (FILTER_BITS)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .filter_len (filter_len),
      .pin        (u_pin_if)
    );
  end

endmodule
